// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment patterns and sizing helper for the scan driver
package display_pkg;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD nibble to active-high seven-segment pattern
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - time-multiplexed seven-segment driver stepped by a slow scan tick
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 95,
  parameter int ACTIVE_LOW = 1
)
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            scan_tick_in,
  input  logic [4*NUM_DIGITS-1:0]         digits_bcd,
  input  logic [NUM_DIGITS-1:0]           blank_mask,
  input  logic [NUM_DIGITS-1:0]           dp_mask,
  input  logic                            blink_en,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [6:0]                      seg,
  output logic                            dp,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int BW = idx_width(BLINK_DIV);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};

  logic          sync1, sync2, prev;
  logic          scan_edge;
  logic [IW-1:0] next_idx;
  logic [3:0]    next_bcd;
  logic [6:0]    next_seg;
  logic          next_dark;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= scan_tick_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign scan_edge = sync2 & ~prev;

  // Everything for the upcoming digit is taken from the index being entered
  assign next_idx  = (digit_idx == LAST_IDX) ? '0 : digit_idx + IW'(1);
  assign next_bcd  = digits_bcd[4*next_idx +: 4];
  assign next_dark = blank_mask[next_idx] | (blink_en & blink_phase);

  seg7_decoder u_dec (
    .bcd (next_bcd),
    .seg (next_seg)
  );

  // Dropping blink_en clears the cadence at once, even on a scan edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (scan_edge) begin
      if (blink_cnt == LAST_CNT) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx <= LAST_IDX;
      an        <= AN_OFF;
      seg       <= {7{POL}};
      dp        <= POL;
    end else if (scan_edge) begin
      digit_idx <= next_idx;
      an        <= next_dark ? AN_OFF : ((NUM_DIGITS'(1) << next_idx) ^ AN_OFF);
      seg       <= next_seg ^ {7{POL}};
      dp        <= dp_mask[next_idx] ^ POL;
    end
  end

endmodule
